exc_cp0_unit: RTL and testbench
===============================

# exc_cp0_unit

Exception source for the pipeline. It sits in the MEM stage, owns the CP0 register set (Count, Compare, Status, Cause, EPC, PRId, Config) and resolves per-instruction exception flags plus pending interrupts into one exception code and a return address. These feed the pipeline controller's `excepttype_i` / `cp0_epc_i` inputs, which drive flush and the new PC. Architectural CP0 state is updated on the clock edge following detection.

## Interface
Parameters:
- `PRID_VALUE`, 32'h004C0102, read-only PRId contents
- `CONFIG_VALUE`, 32'h00008000, read-only Config contents (BE=1)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `int_i`  in  6  external hardware interrupt lines, level-sensitive
- `mem_excepttype_i`  in  32  raw flags from MEM: bit8 syscall, bit9 invalid instruction, bit10 trap, bit11 overflow, bit12 eret
- `mem_pc_i`  in  32  PC of the MEM-stage instruction; 0 means bubble
- `mem_in_delayslot_i`  in  1  MEM instruction is in a branch delay slot
- `we_i`, `waddr_i[4:0]`, `wdata_i[31:0]`  in  CP0 write port (mtc0, committed at WB)
- `raddr_i`  in  5  CP0 read address (mfc0)
- `rdata_o`  out  32  CP0 read data, combinational
- `excepttype_o`  out  32  resolved code: 0x1 int, 0x8 syscall, 0xa invalid, 0xd trap, 0xc ov, 0xe eret, 0 none
- `epc_o`  out  32  EPC with same-cycle write forwarding
- `status_o`, `cause_o`  out  32  current register values
- `timer_int_o`  out  1  Count/Compare match, sticky

## Operation
- Forwarding: effective Status, Cause and EPC are the register value, replaced by `wdata_i` when `we_i` targets that address in the same cycle. Interrupt detection, eret and `epc_o` all use the forwarded values.
- Resolution (combinational, priority order, only when `mem_pc_i != 0`):
  1. Interrupt: `(Cause.IP[7:0] & Status.IM[7:0]) != 0` and EXL=0 and IE=1.
  2. syscall.
  3. invalid.
  4. trap.
  5. ov.
  6. eret.
- Cause.IP[7:2] is sampled from `int_i` every cycle. IP[7] is ORed with `timer_int_o`. IP[1:0] are software-written.
- On a resolved non-eret exception (next edge):
  - EPC = `mem_pc_i`, or `mem_pc_i - 4` when in a delay slot.
  - Cause.BD = `mem_in_delayslot_i`.
  - Cause.ExcCode = code[4:0], with 0 for interrupt.
  - Status.EXL = 1.
  - If EXL was already 1, EPC and BD are left unchanged.
- On eret: Status.EXL = 0.
- Write-port masks:
  - Status: fully writable.
  - Cause: only IP[1:0], IV and WP are writable.
  - EPC, Count, Compare: fully writable.
  - PRId, Config: ignore writes.
- Same cycle write and exception to the same field: the exception update wins.
- Reads of unmapped addresses return 0.

## Timing
- `excepttype_o` and `epc_o` are combinational, with zero-cycle latency to the controller.
- CP0 register updates land at the next rising edge.
- Count increments by 1 every cycle and wraps 0xFFFFFFFF to 0. A Count write loads `wdata_i` in place of the increment.
- `timer_int_o` sets when Count == Compare and Compare != 0. A write to Compare clears it; if set and clear coincide, the clear wins.
- Reset values:
  - Count, Compare, Cause, EPC: 0.
  - Status: 0x10000000.
  - `timer_int_o`: 0.
  - `excepttype_o`: 0.
- Reset asserted mid-exception: registers revert on that edge and no exception update occurs.
- Bubble (`mem_pc_i == 0`): `excepttype_o` = 0 even if an interrupt is pending; the interrupt is taken on the next valid instruction.

## Configuration
- `CP0_TIMER_EN` defined: Count/Compare and `timer_int_o` operate as above.
- Undefined:
  - Count and Compare read 0 and ignore writes.
  - `timer_int_o` is tied 0.
  - IP[7] follows `int_i[5]` only.

## Structure
- Shared defines package:
  - CP0 addresses: Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16.
  - Resolved exception codes and raw flag bit positions.
  - Status/Cause field indices.
- One sub-module, `cp0_timer`: Count, Compare and the sticky match flag. It is instantiated only under `CP0_TIMER_EN`.

## Test plan
- Reset: Status=0x10000000, EPC=0, `excepttype_o`=0 → all hold until the first write.
- syscall flag (bit8) at PC 0x100, not in a delay slot → `excepttype_o`=0x8; next cycle EPC=0x100, ExcCode=8, EXL=1.
- Overflow at PC 0x204 in a delay slot → EPC=0x200, BD=1, `excepttype_o`=0xc.
- Status=0x0000_0401 (IM2, IE), `int_i`=6'b000001, PC 0x300 → `excepttype_o`=0x1 even with bit8 also set; if EXL=1 → 0x8 instead.
- mtc0 EPC=0x500 in the same cycle as eret → `epc_o`=0x500, `excepttype_o`=0xe; next cycle EXL=0.
- `CP0_TIMER_EN`: Compare=5, Count=0 → `timer_int_o`=1 when Count==5; a Compare write clears it.

Source files
------------

// File: rtl/exc_cp0_unit_pkg.sv
// Shared CP0 definitions for the MEM-stage exception unit.
// Contents: data/IRQ widths, CP0 register addresses, resolved exception
// codes, raw MEM exception flag bit positions, Status/Cause field indices,
// reset values and the Cause write mask.
package exc_cp0_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned IRQW = 6;

  // CP0 register addresses
  localparam logic [AW-1:0] CP0_COUNT   = 5'd9;
  localparam logic [AW-1:0] CP0_COMPARE = 5'd11;
  localparam logic [AW-1:0] CP0_STATUS  = 5'd12;
  localparam logic [AW-1:0] CP0_CAUSE   = 5'd13;
  localparam logic [AW-1:0] CP0_EPC     = 5'd14;
  localparam logic [AW-1:0] CP0_PRID    = 5'd15;
  localparam logic [AW-1:0] CP0_CONFIG  = 5'd16;

  // Resolved exception codes handed to the pipeline controller
  localparam logic [XLEN-1:0] EXC_NONE    = 32'h0;
  localparam logic [XLEN-1:0] EXC_INT     = 32'h1;
  localparam logic [XLEN-1:0] EXC_SYSCALL = 32'h8;
  localparam logic [XLEN-1:0] EXC_INVALID = 32'ha;
  localparam logic [XLEN-1:0] EXC_TRAP    = 32'hd;
  localparam logic [XLEN-1:0] EXC_OV      = 32'hc;
  localparam logic [XLEN-1:0] EXC_ERET    = 32'he;

  // Raw flag positions in mem_excepttype_i
  localparam int unsigned FLAG_SYSCALL = 8;
  localparam int unsigned FLAG_INVALID = 9;
  localparam int unsigned FLAG_TRAP    = 10;
  localparam int unsigned FLAG_OV      = 11;
  localparam int unsigned FLAG_ERET    = 12;

  // Status fields
  localparam int unsigned ST_IE    = 0;
  localparam int unsigned ST_EXL   = 1;
  localparam int unsigned ST_IM_LO = 8;

  // Cause fields
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_HW_LO  = 10;
  localparam int unsigned CAUSE_WP     = 22;
  localparam int unsigned CAUSE_IV     = 23;
  localparam int unsigned CAUSE_BD     = 31;

  localparam logic [XLEN-1:0] STATUS_RST  = 32'h1000_0000;
  // Software-writable Cause bits: IV, WP, IP[1:0]
  localparam logic [XLEN-1:0] CAUSE_WMASK = 32'h00C0_0300;

endpackage

// File: rtl/exc_cp0_unit_if.sv
// Pipeline <-> CP0 exception unit bus.
// master: pipeline side (drives MEM-stage info, mtc0 write port, mfc0 address)
// slave : CP0 side (returns read data, resolved exception, EPC, Status, Cause,
//         timer interrupt)
interface exc_cp0_unit_if;
  import exc_cp0_unit_pkg::*;

  logic [IRQW-1:0] int_i;
  logic [XLEN-1:0] mem_excepttype_i;
  logic [XLEN-1:0] mem_pc_i;
  logic            mem_in_delayslot_i;
  logic            we_i;
  logic [AW-1:0]   waddr_i;
  logic [XLEN-1:0] wdata_i;
  logic [AW-1:0]   raddr_i;
  logic [XLEN-1:0] rdata_o;
  logic [XLEN-1:0] excepttype_o;
  logic [XLEN-1:0] epc_o;
  logic [XLEN-1:0] status_o;
  logic [XLEN-1:0] cause_o;
  logic            timer_int_o;

  modport master (
    output int_i, mem_excepttype_i, mem_pc_i, mem_in_delayslot_i,
           we_i, waddr_i, wdata_i, raddr_i,
    input  rdata_o, excepttype_o, epc_o, status_o, cause_o, timer_int_o
  );

  modport slave (
    input  int_i, mem_excepttype_i, mem_pc_i, mem_in_delayslot_i,
           we_i, waddr_i, wdata_i, raddr_i,
    output rdata_o, excepttype_o, epc_o, status_o, cause_o, timer_int_o
  );
endinterface

// File: rtl/exc_cp0_unit_cp0_timer.sv
// cp0_timer: Count/Compare pair with a sticky match flag.
// Only built when CP0_TIMER_EN is defined.
// Ports: clk, rst (sync, active-high), count_we/compare_we + wdata (write
// port), count/compare (register values), timer_int (sticky match).
`ifdef CP0_TIMER_EN
module cp0_timer
  import exc_cp0_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            count_we,
  input  logic            compare_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] count,
  output logic [XLEN-1:0] compare,
  output logic            timer_int
);

  // Free-running counter; a Compare write clears the flag even on a match
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      count <= count_we ? wdata : count + XLEN'(1);
      if (compare_we) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if (count == compare && compare != '0) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/exc_cp0_unit.sv
// exc_cp0_unit: MEM-stage exception resolution and CP0 register file.
// Ports: clk, rst (sync, active-high), bus (exc_cp0_unit_if.slave).
// Parameters: PRID_VALUE, CONFIG_VALUE (read-only register contents).
// Macro CP0_TIMER_EN: enables Count/Compare and the timer interrupt; when
// undefined Count/Compare read 0 and timer_int_o is 0.
module exc_cp0_unit
  import exc_cp0_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] PRID_VALUE   = 32'h004C_0102,
  parameter logic [XLEN-1:0] CONFIG_VALUE = 32'h0000_8000
) (
  input logic               clk,
  input logic               rst,
  exc_cp0_unit_if.slave     bus
);

  logic [XLEN-1:0] status_q, cause_q, epc_q;
  logic [XLEN-1:0] status_d, cause_d, epc_d;
  logic [XLEN-1:0] status_fwd, cause_fwd, epc_fwd;
  logic [XLEN-1:0] count, compare;
  logic            timer_int;
  logic            int_pending;
  logic [XLEN-1:0] exc_code;
  logic [XLEN-1:0] rdata;
  logic            unused_flags;

  assign unused_flags = ^{bus.mem_excepttype_i[31:13], bus.mem_excepttype_i[7:0]};

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (bus.we_i && bus.waddr_i == CP0_COUNT),
    .compare_we (bus.we_i && bus.waddr_i == CP0_COMPARE),
    .wdata      (bus.wdata_i),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int)
  );
`else
  assign count     = '0;
  assign compare   = '0;
  assign timer_int = 1'b0;
`endif

  // Same-cycle mtc0 forwarding; Cause only takes its writable bits
  assign status_fwd = (bus.we_i && bus.waddr_i == CP0_STATUS) ? bus.wdata_i : status_q;
  assign cause_fwd  = (bus.we_i && bus.waddr_i == CP0_CAUSE)
                    ? ((cause_q & ~CAUSE_WMASK) | (bus.wdata_i & CAUSE_WMASK))
                    : cause_q;
  assign epc_fwd    = (bus.we_i && bus.waddr_i == CP0_EPC) ? bus.wdata_i : epc_q;

  assign int_pending = (|(cause_fwd[CAUSE_IP_LO +: 8] & status_fwd[ST_IM_LO +: 8]))
                    && !status_fwd[ST_EXL] && status_fwd[ST_IE];

  // Priority resolution; bubbles and reset never raise an exception
  always_comb begin
    exc_code = EXC_NONE;
    if (!rst && bus.mem_pc_i != '0) begin
      if (int_pending)                                exc_code = EXC_INT;
      else if (bus.mem_excepttype_i[FLAG_SYSCALL])    exc_code = EXC_SYSCALL;
      else if (bus.mem_excepttype_i[FLAG_INVALID])    exc_code = EXC_INVALID;
      else if (bus.mem_excepttype_i[FLAG_TRAP])       exc_code = EXC_TRAP;
      else if (bus.mem_excepttype_i[FLAG_OV])         exc_code = EXC_OV;
      else if (bus.mem_excepttype_i[FLAG_ERET])       exc_code = EXC_ERET;
    end
  end

  // Next register state: forwarded write, hardware IP sampling, then exception override
  always_comb begin
    status_d = status_fwd;
    cause_d  = cause_fwd;
    epc_d    = epc_fwd;
    cause_d[CAUSE_HW_LO +: 6] = {bus.int_i[5] | timer_int, bus.int_i[4:0]};
    if (exc_code == EXC_ERET) begin
      status_d[ST_EXL] = 1'b0;
    end else if (exc_code != EXC_NONE) begin
      // Nested exceptions keep the original return point
      if (!status_fwd[ST_EXL]) begin
        epc_d = bus.mem_in_delayslot_i ? bus.mem_pc_i - 32'd4 : bus.mem_pc_i;
        cause_d[CAUSE_BD] = bus.mem_in_delayslot_i;
      end
      cause_d[CAUSE_EXC_LO +: 5] = (exc_code == EXC_INT) ? 5'd0 : exc_code[4:0];
      status_d[ST_EXL] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RST;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  // mfc0 read mux
  always_comb begin
    rdata = '0;
    case (bus.raddr_i)
      CP0_COUNT:   rdata = count;
      CP0_COMPARE: rdata = compare;
      CP0_STATUS:  rdata = status_q;
      CP0_CAUSE:   rdata = cause_q;
      CP0_EPC:     rdata = epc_q;
      CP0_PRID:    rdata = PRID_VALUE;
      CP0_CONFIG:  rdata = CONFIG_VALUE;
      default:     rdata = '0;
    endcase
  end

  assign bus.rdata_o      = rdata;
  assign bus.excepttype_o = exc_code;
  assign bus.epc_o        = epc_fwd;
  assign bus.status_o     = status_q;
  assign bus.cause_o      = cause_q;
  assign bus.timer_int_o  = timer_int;

endmodule

// File: tb/tb_exc_cp0_unit.sv
// Scoreboard bench for exc_cp0_unit: the driver computes each cycle's
// expected outputs from an architectural model and queues them; a monitor
// pops and compares at the falling edge.
module tb_exc_cp0_unit;
  import exc_cp0_unit_pkg::*;

  localparam logic [31:0] PRID = 32'h004C_0102;
  localparam logic [31:0] CFG  = 32'h0000_8000;
`ifdef CP0_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  exc_cp0_unit_if bus();

  exc_cp0_unit #(.PRID_VALUE(PRID), .CONFIG_VALUE(CFG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exc;
    logic [31:0] epc;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] rdata;
    logic        tmr;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Architectural state of the reference model
  logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;
  logic        m_timer;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: one expectation per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("excepttype", bus.excepttype_o, e.exc);
        chk("epc",        bus.epc_o,        e.epc);
        chk("status",     bus.status_o,     e.status);
        chk("cause",      bus.cause_o,      e.cause);
        chk("rdata",      bus.rdata_o,      e.rdata);
        chk("timer_int",  32'(bus.timer_int_o), 32'(e.tmr));
      end
    end
  end

  task automatic model_reset();
    m_status = 32'h1000_0000; m_cause = '0; m_epc = '0;
    m_count = '0; m_compare = '0; m_timer = 1'b0;
  endtask

  // Drive one cycle, queue the expected view, advance the model past the edge
  task automatic cyc(input logic r, input logic [5:0] irq, input logic [31:0] fl,
                     input logic [31:0] pc, input logic ds, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra);
    exp_t e;
    logic [31:0] st_v, ca_v, ep_v, code, n_status, n_cause, n_epc, n_count, n_compare;
    logic n_timer;
    rst = r;
    bus.int_i = irq; bus.mem_excepttype_i = fl; bus.mem_pc_i = pc;
    bus.mem_in_delayslot_i = ds; bus.we_i = we; bus.waddr_i = wa;
    bus.wdata_i = wd; bus.raddr_i = ra;

    // Values visible to this instruction, including a same-cycle mtc0
    st_v = (we && wa == 5'd12) ? wd : m_status;
    ca_v = (we && wa == 5'd13) ? ((m_cause & 32'hFF3F_FCFF) | (wd & 32'h00C0_0300)) : m_cause;
    ep_v = (we && wa == 5'd14) ? wd : m_epc;

    code = 32'h0;
    if (!r && pc != 0) begin
      if ((ca_v[15:8] & st_v[15:8]) != 0 && st_v[1] == 1'b0 && st_v[0] == 1'b1) code = 32'h1;
      else if (fl[8])  code = 32'h8;
      else if (fl[9])  code = 32'ha;
      else if (fl[10]) code = 32'hd;
      else if (fl[11]) code = 32'hc;
      else if (fl[12]) code = 32'he;
    end

    e.exc = code; e.epc = ep_v; e.status = m_status; e.cause = m_cause; e.tmr = m_timer;
    case (ra)
      5'd9:    e.rdata = m_count;
      5'd11:   e.rdata = m_compare;
      5'd12:   e.rdata = m_status;
      5'd13:   e.rdata = m_cause;
      5'd14:   e.rdata = m_epc;
      5'd15:   e.rdata = PRID;
      5'd16:   e.rdata = CFG;
      default: e.rdata = 32'h0;
    endcase
    sb.push_back(e);

    n_status = st_v; n_cause = ca_v; n_epc = ep_v;
    n_cause[15:10] = {irq[5] | m_timer, irq[4:0]};
    if (code == 32'he) begin
      n_status[1] = 1'b0;
    end else if (code != 0) begin
      if (st_v[1] == 1'b0) begin
        n_epc = ds ? pc - 32'd4 : pc;
        n_cause[31] = ds;
      end
      n_cause[6:2] = (code == 32'h1) ? 5'd0 : code[4:0];
      n_status[1] = 1'b1;
    end
    n_count = m_count; n_compare = m_compare; n_timer = m_timer;
    if (TIMER_EN) begin
      n_count = (we && wa == 5'd9) ? wd : m_count + 32'd1;
      if (we && wa == 5'd11) begin
        n_compare = wd;
        n_timer = 1'b0;
      end else if (m_count == m_compare && m_compare != 0) begin
        n_timer = 1'b1;
      end
    end

    if (r) model_reset();
    else begin
      m_status = n_status; m_cause = n_cause; m_epc = n_epc;
      m_count = n_count; m_compare = n_compare; m_timer = n_timer;
    end
    @(posedge clk); #1;
  endtask

  logic [4:0] addrs [8] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};

  initial begin
    rst = 1'b1;
    bus.int_i = '0; bus.mem_excepttype_i = '0; bus.mem_pc_i = '0;
    bus.mem_in_delayslot_i = 1'b0; bus.we_i = 1'b0; bus.waddr_i = '0;
    bus.wdata_i = '0; bus.raddr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();

    // Reset state holds through idle cycles
    cyc(0, 6'd0, 0, 0, 0, 0, 0, 0, 5'd12);
    cyc(0, 6'd0, 0, 0, 0, 0, 0, 0, 5'd14);
    cyc(0, 6'd0, 0, 0, 0, 0, 0, 0, 5'd15);
    // syscall at 0x100, then return
    cyc(0, 6'd0, 32'h100, 32'h100, 0, 0, 0, 0, 5'd13);
    cyc(0, 6'd0, 0, 0, 0, 0, 0, 0, 5'd14);
    cyc(0, 6'd0, 32'h1000, 32'h104, 0, 0, 0, 0, 5'd12);
    // overflow in a delay slot
    cyc(0, 6'd0, 32'h800, 32'h204, 1, 0, 0, 0, 5'd13);
    cyc(0, 6'd0, 0, 0, 0, 0, 0, 0, 5'd14);
    cyc(0, 6'd0, 32'h1000, 32'h208, 0, 0, 0, 0, 5'd12);
    // interrupt beats syscall; nested syscall keeps EPC
    cyc(0, 6'd1, 0, 0, 0, 1, 5'd12, 32'h0000_0401, 5'd12);
    cyc(0, 6'd1, 32'h100, 32'h300, 0, 0, 0, 0, 5'd13);
    cyc(0, 6'd1, 32'h100, 32'h304, 0, 0, 0, 0, 5'd13);
    // eret with same-cycle EPC write
    cyc(0, 6'd1, 32'h1000, 32'h308, 0, 1, 5'd14, 32'h500, 5'd14);
    // bubble hides the pending interrupt, next instruction takes it
    cyc(0, 6'd1, 0, 0, 0, 0, 0, 0, 5'd12);
    cyc(0, 6'd0, 0, 32'h30c, 0, 0, 0, 0, 5'd12);
    cyc(0, 6'd0, 32'h1000, 32'h310, 0, 0, 0, 0, 5'd13);
    // Cause write mask, PRId/Config writes ignored
    cyc(0, 6'd0, 0, 0, 0, 1, 5'd13, 32'hFFFF_FFFF, 5'd13);
    cyc(0, 6'd0, 0, 0, 0, 1, 5'd15, 32'hDEAD_BEEF, 5'd15);
    cyc(0, 6'd0, 0, 0, 0, 1, 5'd16, 32'hDEAD_BEEF, 5'd16);
    // timer: Count=0, Compare=5, then a Compare write clears the flag
    cyc(0, 6'd0, 0, 0, 0, 1, 5'd9, 32'h0, 5'd9);
    cyc(0, 6'd0, 0, 0, 0, 1, 5'd11, 32'h5, 5'd11);
    for (int i = 0; i < 8; i++) cyc(0, 6'd0, 0, 0, 0, 0, 0, 0, 5'd9);
    cyc(0, 6'd0, 0, 0, 0, 1, 5'd11, 32'h0, 5'd11);
    cyc(0, 6'd0, 0, 0, 0, 0, 0, 0, 5'd9);
    // reset during an exception
    cyc(1, 6'd0, 32'h100, 32'h400, 0, 0, 0, 0, 5'd12);
    cyc(0, 6'd0, 0, 0, 0, 0, 0, 0, 5'd14);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] fl, pc, wd;
      logic [5:0]  irq;
      logic [4:0]  wa, ra;
      logic        we, ds;
      int unsigned k;
      pc = ($urandom_range(0, 3) == 0) ? 32'h0 : (32'($urandom_range(1, 1023)) << 2);
      k = $urandom_range(0, 11);
      if (k <= 4) fl = 32'h1 << (8 + k);
      else if (k == 5) fl = 32'($urandom) & 32'h0000_1F00;
      else fl = 32'h0;
      if ($urandom_range(0, 7) == 0) fl = fl | (32'($urandom) & 32'hFFFF_E0FF);
      ds = 1'($urandom);
      irq = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      we = ($urandom_range(0, 3) == 0);
      wa = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 7)];
      if (wa == 5'd12)
        wd = (32'($urandom) & 32'h1000_FF01) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
      else if (wa == 5'd9 || wa == 5'd11)
        wd = 32'($urandom_range(0, 40));
      else
        wd = 32'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 7)];
      cyc(($urandom_range(0, 499) == 0), irq, fl, pc, ds, we, wa, wd, ra);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
